med_dispense_scheduler: RTL and testbench
=========================================

# med_dispense_scheduler

Parametrised medication scheduler with multiple slots, a prescaled wrapping timebase, and per-slot due/acknowledge/miss tracking. Every taken or missed dose is written to an event-log FIFO that the host reads over a valid/ready port. It is the successor to the single-entry scheduler/logger path and sits between the user-input decoder and the LCD/output controller.

## Interface
- NUM_SLOTS, 8, number of schedulable medication slots (2–16); SLOT_W = $clog2(NUM_SLOTS)
- TIME_W, 8, timebase width; time wraps modulo 2^TIME_W
- PRESCALE, 4, clk cycles per time tick (≥1)
- MISS_TICKS, 16, ticks a dose may stay pending before it is declared missed (1 ≤ MISS_TICKS < 2^TIME_W)
- LOG_DEPTH, 16, log FIFO entries (power of 2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- prog_valid  in  1  write slot config this cycle
- prog_slot  in  SLOT_W  slot index
- prog_time  in  TIME_W  due time
- prog_en  in  1  slot enable
- ack_valid  in  1  patient acknowledges a dose
- ack_slot  in  SLOT_W  slot acknowledged
- log_ready  in  1  host pops log head
- ovf_clr  in  1  clear overflow flag
- cur_time  out  TIME_W  current timebase value
- pending  out  NUM_SLOTS  per-slot dose-due flags
- alarm  out  1  OR of pending
- log_valid  out  1  FIFO non-empty
- log_data  out  1+SLOT_W+TIME_W  head entry {missed, slot, timestamp}
- log_count  out  $clog2(LOG_DEPTH)+1  occupancy
- log_ovf  out  1  sticky overflow flag

## Operation
- Reset: all slots disabled with time 0. cur_time, prescaler, pending, age counters, miss bitmap, FIFO pointers, log_count and log_ovf are all 0. log_valid is 0.
- Timebase: the prescaler counts 0..PRESCALE-1. When it is at PRESCALE-1, cur_time increments (wrapping 2^TIME_W-1 → 0) and the internal tick_d pulses high for one cycle on the following cycle.
- Due: when tick_d is high, pending[i] is set if slot i is enabled and slot_time[i] == cur_time. A slot matches at most once per timebase value.
- Age: while pending[i] is set, age[i] increments on each tick_d. On the tick_d where age reaches MISS_TICKS:
  - pending[i] clears,
  - age[i] clears,
  - miss_bm[i] is set.
- Ack: an ack_valid to a pending slot clears pending and age, and writes the log entry {0, slot, cur_time}. An ack to a non-pending slot is ignored and produces no log entry.
- Miss drain: in any cycle with no ack log write, the lowest set miss_bm bit is cleared and writes {1, slot, cur_time}. This is at most one log write per cycle, and ack has priority.
- Program: prog_valid writes time and enable to the slot, and clears that slot's pending, age and miss_bm without logging.
- Simultaneous events on one slot:
  - ack and miss timeout in the same cycle: the ack wins and the dose is logged as taken.
  - ack and prog in the same cycle: the ack is logged first, then the new config applies.
  - due and prog in the same cycle: prog wins and pending stays 0.
- FIFO:
  - Push and pop in the same cycle when full: both are accepted and the count is unchanged.
  - Push when full with no pop: the entry is dropped and log_ovf is set. A drained miss_bm bit is considered consumed even when its entry is dropped.
  - Pop when empty: ignored.
- log_ovf: stays set until ovf_clr or reset. If ovf_clr coincides with a new overflow, the flag is set.

## Timing
- cur_time changes on the edge where the prescaler is at PRESCALE-1.
- pending rises one cycle after cur_time becomes equal to the slot time.
- alarm is a combinational OR of the pending register.
- Ack handling:
  - an ack sampled at edge N clears pending at edge N;
  - the entry is visible on log_data / log_valid after edge N (1-cycle latency) when the FIFO was empty.
- log_data is the registered FIFO head and is valid whenever log_valid is high. A pop occurs on an edge where log_valid && log_ready.
- Asynchronous reset mid-operation returns every output to its reset value immediately. There is no partial log write.

## Structure
- Package med_sched_pkg holds:
  - a log entry struct with fields missed, slot and timestamp, together with width localparams derived from NUM_SLOTS and TIME_W;
  - function slot_w(n);
  - the lowest-set-bit priority encoder function.
- Sub-module med_log_fifo, parametrised by width and depth, owns the storage, pointers, count and overflow logic. The top level contains the timebase, slot registers, pending/age/miss logic and log-write arbitration.

## Test plan
- Timebase: reset, then 40 cycles idle with PRESCALE=4 → cur_time reads 10. Drive to 255 → it wraps to 0 and pending stays 0.
- Taken dose: program slot 2 with time 5 and enable, run to cur_time=5 → pending=8'h04 and alarm=1. ack_slot=2 → pending=0, log_data={0,2,5}, log_count=1.
- Missed dose: slot 1 due at 3 with no ack, MISS_TICKS=16 → pending[1] clears at cur_time=19 and log_data={1,1,19}.
- Collision: slots 0 and 3 both time 7 → both pending. Ack slot 3 while slot 0 times out in the same cycle → the ack entry is logged first, then {1,0,…} on the next cycle, with entries in that order.
- Overflow: LOG_DEPTH=16 with 17 acks and no pops → log_count=16, log_ovf=1, and the 17th entry is absent. A push and pop in the same cycle while full → count stays 16. Pulse ovf_clr → log_ovf=0.
- Edge cases:
  - ack to a non-pending slot → no entry;
  - reprogramming a pending slot → pending clears with no entry;
  - rst_n asserted while FIFO holds 5 entries → log_count=0, log_valid=0.

Source files
------------

// File: rtl/med_sched_pkg.sv
// Shared types and helpers for the medication scheduler: log entry layout,
// slot index width and the lowest-set-bit encoder used to drain missed doses.
package med_sched_pkg;

  localparam int MAX_SLOTS     = 16;
  localparam int IDX_W         = 4;
  localparam int NUM_SLOTS_DEF = 8;
  localparam int TIME_W_DEF    = 8;

  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int SLOT_W_DEF  = slot_w(NUM_SLOTS_DEF);
  localparam int ENTRY_W_DEF = 1 + SLOT_W_DEF + TIME_W_DEF;

  typedef struct packed {
    logic                  missed;
    logic [SLOT_W_DEF-1:0] slot;
    logic [TIME_W_DEF-1:0] timestamp;
  } log_entry_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } lsb_t;

  function automatic lsb_t lowest_set(input logic [MAX_SLOTS-1:0] vec);
    lsb_t res;
    res = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/med_dispense_scheduler_if.sv
// Host-side bundle of the scheduler: slot programming, dose acknowledge,
// status outputs and the event-log read port.
interface med_dispense_scheduler_if
  import med_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int TIME_W    = 8,
  parameter int LOG_DEPTH = 16
);
  localparam int SLOT_W  = slot_w(NUM_SLOTS);
  localparam int ENTRY_W = 1 + SLOT_W + TIME_W;
  localparam int CNT_W   = $clog2(LOG_DEPTH) + 1;

  logic                 prog_valid;
  logic [SLOT_W-1:0]    prog_slot;
  logic [TIME_W-1:0]    prog_time;
  logic                 prog_en;
  logic                 ack_valid;
  logic [SLOT_W-1:0]    ack_slot;
  logic                 log_ready;
  logic                 ovf_clr;
  logic [TIME_W-1:0]    cur_time;
  logic [NUM_SLOTS-1:0] pending;
  logic                 alarm;
  logic                 log_valid;
  logic [ENTRY_W-1:0]   log_data;
  logic [CNT_W-1:0]     log_count;
  logic                 log_ovf;

  modport master (
    output prog_valid, prog_slot, prog_time, prog_en, ack_valid, ack_slot,
           log_ready, ovf_clr,
    input  cur_time, pending, alarm, log_valid, log_data, log_count, log_ovf
  );

  modport slave (
    input  prog_valid, prog_slot, prog_time, prog_en, ack_valid, ack_slot,
           log_ready, ovf_clr,
    output cur_time, pending, alarm, log_valid, log_data, log_count, log_ovf
  );

endinterface

// File: rtl/med_log_fifo.sv
// Event-log FIFO: register storage with a gated head, occupancy count and a
// sticky overflow flag for entries dropped while full.
module med_log_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       ovf_clr_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, do_pop, do_push;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = (ovf_q && !ovf_clr_i) || (push_i && full && !do_pop);
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/med_dispense_scheduler.sv
// Multi-slot medication scheduler: prescaled timebase, per-slot due/age/miss
// tracking, and arbitration of taken/missed events into the log FIFO.
module med_dispense_scheduler
  import med_sched_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int TIME_W     = 8,
  parameter int PRESCALE   = 4,
  parameter int MISS_TICKS = 16,
  parameter int LOG_DEPTH  = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  med_dispense_scheduler_if.slave bus
);
  localparam int SLOT_W  = slot_w(NUM_SLOTS);
  localparam int ENTRY_W = 1 + SLOT_W + TIME_W;
  localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic                 tick_q, tick_d;
  logic [TIME_W-1:0]    slot_time_q [NUM_SLOTS];
  logic [TIME_W-1:0]    slot_time_d [NUM_SLOTS];
  logic [TIME_W-1:0]    age_q [NUM_SLOTS];
  logic [TIME_W-1:0]    age_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_en_q, slot_en_d;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [NUM_SLOTS-1:0] miss_q, miss_d;
  logic                 ack_hit, push;
  logic [ENTRY_W-1:0]   entry;
  lsb_t                 drain;

  always_comb begin
    presc_d = presc_q + 1'b1;
    time_d  = time_q;
    tick_d  = 1'b0;
    if (presc_q == PRE_W'(PRESCALE - 1)) begin
      presc_d = '0;
      time_d  = time_q + 1'b1;
      tick_d  = 1'b1;
    end
  end

  always_comb begin
    ack_hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.ack_valid && pending_q[i] && bus.ack_slot == SLOT_W'(i)) ack_hit = 1'b1;
    end
  end

  // One log write per cycle: an ack takes the slot, otherwise the lowest missed dose.
  assign drain = lowest_set(MAX_SLOTS'(miss_q));
  assign push  = ack_hit || drain.found;
  assign entry = ack_hit ? {1'b0, bus.ack_slot, time_q}
                         : {1'b1, SLOT_W'(drain.idx), time_q};

  always_comb begin
    slot_time_d = slot_time_q;
    slot_en_d   = slot_en_q;
    pending_d   = pending_q;
    age_d       = age_q;
    miss_d      = miss_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!ack_hit && drain.found && drain.idx == IDX_W'(i)) miss_d[i] = 1'b0;
      if (tick_q) begin
        if (pending_q[i]) begin
          if (age_q[i] == TIME_W'(MISS_TICKS - 1)) begin
            pending_d[i] = 1'b0;
            age_d[i]     = '0;
            miss_d[i]    = 1'b1;
          end else begin
            age_d[i] = age_q[i] + 1'b1;
          end
        end else if (slot_en_q[i] && slot_time_q[i] == time_q) begin
          pending_d[i] = 1'b1;
        end
      end
      // An ack overrides a same-cycle timeout; a reprogram overrides everything.
      if (bus.ack_valid && pending_q[i] && bus.ack_slot == SLOT_W'(i)) begin
        pending_d[i] = 1'b0;
        age_d[i]     = '0;
        miss_d[i]    = miss_q[i];
      end
      if (bus.prog_valid && bus.prog_slot == SLOT_W'(i)) begin
        slot_time_d[i] = bus.prog_time;
        slot_en_d[i]   = bus.prog_en;
        pending_d[i]   = 1'b0;
        age_d[i]       = '0;
        miss_d[i]      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      time_q    <= '0;
      tick_q    <= 1'b0;
      slot_en_q <= '0;
      pending_q <= '0;
      miss_q    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_time_q[i] <= '0;
        age_q[i]       <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      time_q      <= time_d;
      tick_q      <= tick_d;
      slot_en_q   <= slot_en_d;
      pending_q   <= pending_d;
      miss_q      <= miss_d;
      slot_time_q <= slot_time_d;
      age_q       <= age_d;
    end
  end

  med_log_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(LOG_DEPTH)
  ) u_log_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .data_i    (entry),
    .pop_i     (bus.log_ready),
    .ovf_clr_i (bus.ovf_clr),
    .valid_o   (bus.log_valid),
    .data_o    (bus.log_data),
    .count_o   (bus.log_count),
    .ovf_o     (bus.log_ovf)
  );

  assign bus.cur_time = time_q;
  assign bus.pending  = pending_q;
  assign bus.alarm    = |pending_q;

endmodule

// File: tb/tb_med_dispense_scheduler.sv
// Directed and randomised bench for med_dispense_scheduler, checked against a
// reference model that tracks doses in absolute tick counts and a log queue.
module tb_med_dispense_scheduler;
  import med_sched_pkg::*;

  localparam int NS         = 8;
  localparam int TW         = 8;
  localparam int PRESCALE   = 4;
  localparam int MISS_TICKS = 16;
  localparam int DEPTH      = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tbTotal = 0;
  int   tbBad   = 0;

  med_dispense_scheduler_if #(.NUM_SLOTS(NS), .TIME_W(TW), .LOG_DEPTH(DEPTH)) bus ();

  med_dispense_scheduler #(
    .NUM_SLOTS(NS), .TIME_W(TW), .PRESCALE(PRESCALE),
    .MISS_TICKS(MISS_TICKS), .LOG_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mK counts clock edges since reset, doses are aged by tick index.
  int         mK;
  int         mDue  [NS];
  bit [TW-1:0] mTime [NS];
  bit         mEn   [NS];
  bit         mPend [NS];
  bit         mMiss [NS];
  bit         mOvf;
  log_entry_t mLog [$];

  function automatic log_entry_t mkEntry(input bit missed, input int slot, input int ts);
    log_entry_t e;
    e.missed    = missed;
    e.slot      = SLOT_W_DEF'(slot);
    e.timestamp = TIME_W_DEF'(ts);
    return e;
  endfunction

  function automatic int modelTime();
    return (mK / PRESCALE) % 256;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tbTotal++;
    if (observed !== expected) begin
      tbBad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mK = 0;
    mOvf = 1'b0;
    mLog.delete();
    for (int i = 0; i < NS; i++) begin
      mDue[i] = 0; mTime[i] = '0; mEn[i] = 1'b0; mPend[i] = 1'b0; mMiss[i] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    bit         tickNow, ackHit, havePush, popped;
    int         tickIdx, drainIdx, ackSlot;
    log_entry_t e;
    tickNow  = (mK > 0) && (mK % PRESCALE == 0);
    tickIdx  = mK / PRESCALE;
    ackSlot  = int'(bus.ack_slot);
    ackHit   = bus.ack_valid && mPend[ackSlot];
    havePush = 1'b0;
    drainIdx = -1;
    e        = '0;
    if (ackHit) begin
      e = mkEntry(1'b0, ackSlot, modelTime());
      havePush = 1'b1;
    end else begin
      for (int i = NS - 1; i >= 0; i--) if (mMiss[i]) drainIdx = i;
      if (drainIdx >= 0) begin
        e = mkEntry(1'b1, drainIdx, modelTime());
        havePush = 1'b1;
        mMiss[drainIdx] = 1'b0;
      end
    end
    if (tickNow) begin
      for (int i = 0; i < NS; i++) begin
        if (mPend[i]) begin
          if (tickIdx - mDue[i] == MISS_TICKS) begin
            mPend[i] = 1'b0;
            if (!(ackHit && i == ackSlot)) mMiss[i] = 1'b1;
          end
        end else if (mEn[i] && int'(mTime[i]) == modelTime()) begin
          mPend[i] = 1'b1;
          mDue[i]  = tickIdx;
        end
      end
    end
    if (ackHit) mPend[ackSlot] = 1'b0;
    if (bus.prog_valid) begin
      mTime[bus.prog_slot] = bus.prog_time;
      mEn[bus.prog_slot]   = bus.prog_en;
      mPend[bus.prog_slot] = 1'b0;
      mMiss[bus.prog_slot] = 1'b0;
    end
    popped = (mLog.size() > 0) && bus.log_ready;
    if (popped) void'(mLog.pop_front());
    mOvf = mOvf && !bus.ovf_clr;
    if (havePush) begin
      if (mLog.size() < DEPTH) mLog.push_back(e);
      else mOvf = 1'b1;
    end
    mK++;
  endtask

  task automatic checkModel();
    logic [NS-1:0] pm;
    for (int i = 0; i < NS; i++) pm[i] = mPend[i];
    checkOutput("cur_time", 32'(bus.cur_time), 32'(modelTime()));
    checkOutput("pending", 32'(bus.pending), 32'(pm));
    checkOutput("alarm", 32'(bus.alarm), 32'(|pm));
    checkOutput("log_valid", 32'(bus.log_valid), 32'(mLog.size() > 0));
    checkOutput("log_count", 32'(bus.log_count), 32'(mLog.size()));
    checkOutput("log_ovf", 32'(bus.log_ovf), 32'(mOvf));
    checkOutput("log_data", 32'(bus.log_data), (mLog.size() > 0) ? 32'(mLog[0]) : 32'd0);
  endtask

  task automatic idle();
    bus.prog_valid = 1'b0; bus.prog_slot = '0; bus.prog_time = '0; bus.prog_en = 1'b0;
    bus.ack_valid  = 1'b0; bus.ack_slot  = '0;
    bus.log_ready  = 1'b0; bus.ovf_clr   = 1'b0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  task automatic applyReset();
    idle();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkModel();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic progSlot(input int slot, input int t, input bit en);
    idle();
    bus.prog_valid = 1'b1; bus.prog_slot = 3'(slot); bus.prog_time = 8'(t); bus.prog_en = en;
    applyStimulus();
    idle();
  endtask

  task automatic ackSlot(input int slot, input bit pop);
    idle();
    bus.ack_valid = 1'b1; bus.ack_slot = 3'(slot); bus.log_ready = pop;
    applyStimulus();
    idle();
  endtask

  task automatic doRound(input int t, input int n, input bit popOnAck);
    logic [NS-1:0] mask;
    int guard;
    mask = NS'((1 << n) - 1);
    for (int s = 0; s < n; s++) progSlot(s, t, 1'b1);
    guard = 0;
    while ((bus.pending & mask) != mask && guard < 2000) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 2000) checkOutput("round_wait", 32'(bus.pending), 32'(mask));
    for (int s = 0; s < n; s++) ackSlot(s, popOnAck);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    idle();
    @(negedge clk);

    // Timebase count and wrap
    applyReset();
    for (int c = 0; c < 40; c++) applyStimulus();
    checkOutput("time_after_40", 32'(bus.cur_time), 32'd10);
    guard = 0;
    while (bus.cur_time != 8'd255 && guard < 2000) begin applyStimulus(); guard++; end
    while (bus.cur_time != 8'd0 && guard < 2010) begin applyStimulus(); guard++; end
    checkOutput("wrap_time", 32'(bus.cur_time), 32'd0);
    checkOutput("wrap_pending", 32'(bus.pending), 32'd0);

    // Taken dose
    applyReset();
    progSlot(2, 5, 1'b1);
    guard = 0;
    while (!bus.pending[2] && guard < 2000) begin applyStimulus(); guard++; end
    checkOutput("taken_time", 32'(bus.cur_time), 32'd5);
    checkOutput("taken_pending", 32'(bus.pending), 32'h04);
    checkOutput("taken_alarm", 32'(bus.alarm), 32'd1);
    ackSlot(2, 1'b0);
    checkOutput("taken_cleared", 32'(bus.pending), 32'd0);
    checkOutput("taken_entry", 32'(bus.log_data), 32'(mkEntry(1'b0, 2, 5)));
    checkOutput("taken_count", 32'(bus.log_count), 32'd1);

    // Missed dose
    applyReset();
    progSlot(1, 3, 1'b1);
    guard = 0;
    while (!bus.pending[1] && guard < 2000) begin applyStimulus(); guard++; end
    while (bus.pending[1] && guard < 2200) begin applyStimulus(); guard++; end
    checkOutput("miss_clear_time", 32'(bus.cur_time), 32'd19);
    applyStimulus();
    checkOutput("miss_entry", 32'(bus.log_data), 32'(mkEntry(1'b1, 1, 19)));

    // Ack and timeout collide on different slots
    applyReset();
    progSlot(0, 7, 1'b1);
    progSlot(3, 7, 1'b1);
    guard = 0;
    while (bus.cur_time != 8'd23 && guard < 2000) begin applyStimulus(); guard++; end
    checkOutput("coll_both_pending", 32'(bus.pending), 32'h09);
    ackSlot(3, 1'b0);
    checkOutput("coll_pending", 32'(bus.pending), 32'd0);
    checkOutput("coll_first", 32'(bus.log_data), 32'(mkEntry(1'b0, 3, 23)));
    bus.log_ready = 1'b1;
    applyStimulus();
    idle();
    checkOutput("coll_second", 32'(bus.log_data), 32'(mkEntry(1'b1, 0, 23)));
    checkOutput("coll_count", 32'(bus.log_count), 32'd1);

    // Overflow, full push+pop, overflow clear
    applyReset();
    doRound(4, 8, 1'b0);
    doRound(12, 8, 1'b0);
    doRound(20, 1, 1'b0);
    checkOutput("ovf_count", 32'(bus.log_count), 32'd16);
    checkOutput("ovf_flag", 32'(bus.log_ovf), 32'd1);
    doRound(28, 1, 1'b1);
    checkOutput("full_pushpop", 32'(bus.log_count), 32'd16);
    bus.ovf_clr = 1'b1;
    applyStimulus();
    idle();
    checkOutput("ovf_cleared", 32'(bus.log_ovf), 32'd0);

    // Ack to idle slot, reprogram of a pending slot, reset with entries held
    applyReset();
    ackSlot(6, 1'b0);
    checkOutput("ack_idle_count", 32'(bus.log_count), 32'd0);
    progSlot(5, 3, 1'b1);
    guard = 0;
    while (!bus.pending[5] && guard < 2000) begin applyStimulus(); guard++; end
    progSlot(5, 100, 1'b1);
    checkOutput("reprog_pending", 32'(bus.pending), 32'd0);
    checkOutput("reprog_count", 32'(bus.log_count), 32'd0);
    doRound(40, 5, 1'b0);
    checkOutput("five_entries", 32'(bus.log_count), 32'd5);
    applyReset();
    checkOutput("rst_count", 32'(bus.log_count), 32'd0);
    checkOutput("rst_valid", 32'(bus.log_valid), 32'd0);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      idle();
      if ($urandom_range(0, 15) == 0) begin
        bus.prog_valid = 1'b1;
        bus.prog_slot  = 3'($urandom_range(0, NS - 1));
        bus.prog_time  = 8'(modelTime() + int'($urandom_range(1, 12)));
        bus.prog_en    = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.ack_valid = 1'b1;
        bus.ack_slot  = 3'($urandom_range(0, NS - 1));
      end
      bus.log_ready = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.ovf_clr   = ($urandom_range(0, 49) == 0);
      if (c == 3000) applyReset();
      else applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", tbTotal, tbBad);
    $finish;
  end

endmodule
